// File: rtl/ysyx_22051468_pc_ctrl.sv
// Fetch PC owner and redirect controller.
// Issues fetch requests, flushes on redirect, halts on ebreak.
module ysyx_22051468_pc_ctrl #(
  parameter int unsigned    WIDTH        = 64,
  parameter logic [WIDTH-1:0] RESET_PC   = 64'h8000_0000,
  parameter int unsigned    FLUSH_CYCLES = 2,
  parameter int unsigned    CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_jump_en_i,
  input  logic [WIDTH-1:0]     branch_jump_addr_i,
  input  logic                 hold_pipeline_en_i,
  input  logic                 ebreak_i,
  input  logic                 if_ready_i,
  output logic [WIDTH-1:0]     pc_o,
  output logic                 pc_valid_o,
  output logic                 flush_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] redirect_cnt_o,
  output logic [CNT_WIDTH-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [2:0]           fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0] fetch_q, fetch_d;

  logic do_halt;
  logic do_redir;
  logic do_hold;
  logic do_fetch;

  // Mutually exclusive RUN-state events in priority order
  always_comb begin
    do_halt  = ebreak_i;
    do_redir = branch_jump_en_i & ~ebreak_i;
    do_hold  = hold_pipeline_en_i & ~branch_jump_en_i & ~ebreak_i;
    do_fetch = if_ready_i & ~hold_pipeline_en_i
             & ~branch_jump_en_i & ~ebreak_i;
  end

  // Next-state, next-PC, counters and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fcnt_d     = fcnt_q;
    rcnt_d     = rcnt_q;
    fetch_d    = fetch_q;
    pc_valid_o = 1'b0;
    flush_o    = 1'b0;
    halted_o   = 1'b0;
    unique case (state_q)
      RUN: begin
        pc_valid_o = 1'b1;
        unique case (1'b1)
          do_halt: begin
            state_d = HALT;
          end
          do_redir: begin
            flush_o = 1'b1;
            pc_d    = {branch_jump_addr_i[WIDTH-1:1], 1'b0};
            state_d = FLUSH;
            fcnt_d  = FLUSH_INIT;
            rcnt_d  = rcnt_q + CNT_ONE;
          end
          do_hold: begin
            pc_d = pc_q;
          end
          do_fetch: begin
            pc_d    = pc_q + PC_STEP;
            fetch_d = fetch_q + CNT_ONE;
          end
          default: begin
            pc_d = pc_q;
          end
        endcase
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (fcnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fcnt_q  <= 3'd0;
      rcnt_q  <= '0;
      fetch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      fetch_q <= fetch_d;
    end
  end

  assign pc_o           = pc_q;
  assign redirect_cnt_o = rcnt_q;
  assign fetch_cnt_o    = fetch_q;

endmodule

// File: tb/tb_ysyx_22051468_pc_ctrl.sv
// Directed bench for ysyx_22051468_pc_ctrl.
// Counters built 4 bits wide so wrap is reachable.
module tb_ysyx_22051468_pc_ctrl;

  localparam int CW = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic          clk;
  logic          rst;
  logic          bje;
  logic [63:0]   baddr;
  logic          hold;
  logic          ebrk;
  logic          rdy;
  logic [63:0]   pc;
  logic          pc_valid;
  logic          flush;
  logic          halted;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] fcnt;

  int checks = 0;
  int errors = 0;

  ysyx_22051468_pc_ctrl #(
    .WIDTH(64),
    .RESET_PC(RPC),
    .FLUSH_CYCLES(2),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .branch_jump_en_i(bje),
    .branch_jump_addr_i(baddr),
    .hold_pipeline_en_i(hold),
    .ebreak_i(ebrk),
    .if_ready_i(rdy),
    .pc_o(pc),
    .pc_valid_o(pc_valid),
    .flush_o(flush),
    .halted_o(halted),
    .redirect_cnt_o(rcnt),
    .fetch_cnt_o(fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bje;
    logic [63:0] addr;
    logic        hold;
    logic        ebrk;
    logic        rdy;
    logic [63:0] pc;
    logic        valid;
    logic        flush;
    logic        halted;
    int          rcnt;
    int          fcnt;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] e_pc,
                         input logic e_v, input logic e_f,
                         input logic e_h, input int e_r, input int e_c);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " valid"}, 64'(pc_valid), 64'(e_v));
    chk({tag, " flush"}, 64'(flush), 64'(e_f));
    chk({tag, " halted"}, 64'(halted), 64'(e_h));
    chk({tag, " rcnt"}, 64'(rcnt), 64'(e_r));
    chk({tag, " fcnt"}, 64'(fcnt), 64'(e_c));
  endtask

  task automatic add(input logic b, input logic [63:0] a,
                     input logic h, input logic e, input logic r,
                     input logic [63:0] p, input logic vl,
                     input logic f, input logic hl,
                     input int rc, input int fc);
    vec_t t;
    t.bje = b; t.addr = a; t.hold = h; t.ebrk = e; t.rdy = r;
    t.pc = p; t.valid = vl; t.flush = f; t.halted = hl;
    t.rcnt = rc; t.fcnt = fc;
    v.push_back(t);
  endtask

  task automatic drive(input logic b, input logic [63:0] a,
                       input logic h, input logic e, input logic r);
    bje = b; baddr = a; hold = h; ebrk = e; rdy = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // in: bje addr hold ebrk rdy | out: pc valid flush halted rcnt fcnt
    add(0, 0, 0, 0, 1, 64'h8000_0000, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 64'h8000_0004, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 64'h8000_0008, 1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 64'h8000_0008, 1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 64'h8000_0008, 1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 64'h8000_0008, 1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 64'h8000_000C, 1, 0, 0, 0, 3);
    add(0, 0, 1, 0, 1, 64'h8000_0010, 1, 0, 0, 0, 4);
    add(0, 0, 0, 0, 1, 64'h8000_0010, 1, 0, 0, 0, 4);
    // redirect T, stale redirect/ebreak during FLUSH ignored
    add(1, 64'h8000_0101, 0, 0, 1, 64'h8000_0014, 1, 1, 0, 0, 5);
    add(1, 64'h8000_2000, 1, 0, 1, 64'h8000_0100, 0, 1, 0, 1, 5);
    add(0, 0, 0, 1, 1, 64'h8000_0100, 0, 1, 0, 1, 5);
    add(0, 0, 0, 0, 1, 64'h8000_0100, 1, 0, 0, 1, 5);
    add(0, 0, 0, 0, 1, 64'h8000_0104, 1, 0, 0, 1, 6);
    // bit 1 of target kept, bit 0 cleared
    add(1, 64'h8000_0203, 0, 0, 0, 64'h8000_0108, 1, 1, 0, 1, 7);
    add(0, 0, 0, 0, 1, 64'h8000_0202, 0, 1, 0, 2, 7);
    add(0, 0, 0, 0, 1, 64'h8000_0202, 0, 1, 0, 2, 7);
    add(0, 0, 0, 0, 0, 64'h8000_0202, 1, 0, 0, 2, 7);
    // ebreak wins over simultaneous redirect
    add(1, 64'h8000_3000, 0, 1, 1, 64'h8000_0202, 1, 0, 0, 2, 7);
    add(0, 0, 0, 0, 1, 64'h8000_0202, 0, 0, 1, 2, 7);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (v[i]) begin
      drive(v[i].bje, v[i].addr, v[i].hold, v[i].ebrk, v[i].rdy);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), v[i].pc, v[i].valid,
              v[i].flush, v[i].halted, v[i].rcnt, v[i].fcnt);
      next_cycle();
    end

    // HALT absorbs random activity
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom), {32'h0, $urandom}, 1'($urandom),
            1'($urandom), 1'($urandom));
      @(negedge clk);
      chk_all("halt", 64'h8000_0202, 0, 0, 1, 2, 7);
      next_cycle();
    end

    // reset releases HALT
    rst = 1'b1;
    drive(0, 0, 0, 0, 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_all("post_halt_rst", RPC, 1, 0, 0, 0, 0);

    // fetch counter wrap at 2^CW
    for (int i = 0; i < 15; i++) next_cycle();
    @(negedge clk);
    chk_all("cnt15", RPC + 64'd60, 1, 0, 0, 0, 15);
    next_cycle();
    @(negedge clk);
    chk_all("cnt_wrap0", RPC + 64'd64, 1, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk_all("cnt_wrap1", RPC + 64'd68, 1, 0, 0, 0, 1);

    // reset in the middle of FLUSH discards the target
    next_cycle();
    drive(1, 64'h8000_4000, 0, 0, 1);
    next_cycle();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk_all("mid_flush", 64'h8000_4000, 0, 1, 0, 1, 2);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("flush_rst", RPC, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22051468_pc_ctrl.md
# ysyx_22051468_pc_ctrl

Program-counter and redirect controller sitting between the Exec stage and instruction fetch. Consumes the Exec stage's `branch_jump_en` / `branch_jump_addr_o` / `hold_pipeline_en` outputs and the ebreak indication, owns the architectural fetch PC, and issues fetch requests with a valid/ready handshake. Generates pipeline flush windows on redirects and a sticky halt. Keeps redirect and fetch event counters for perf/difftest.

## Interface
- `WIDTH`, 64, PC/data width.
- `RESET_PC`, 64'h8000_0000, PC loaded by reset.
- `FLUSH_CYCLES`, 2, bubble cycles after a redirect; legal range 1..7 (fetch latency).
- `CNT_WIDTH`, 32, width of event counters.

Clocking and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `branch_jump_en_i`  in  1  redirect request from Exec.
- `branch_jump_addr_i`  in  WIDTH  redirect target from Exec.
- `hold_pipeline_en_i`  in  1  Exec stall request; no PC advance this cycle.
- `ebreak_i`  in  1  ebreak in Exec; halts fetch.
- `if_ready_i`  in  1  fetch accepts `pc_o` this cycle.
- `pc_o`  out  WIDTH  fetch address.
- `pc_valid_o`  out  1  `pc_o` is a valid fetch request.
- `flush_o`  out  1  kill IF/ID and ID/EX contents at next edge.
- `halted_o`  out  1  sticky halt indication.
- `redirect_cnt_o`  out  CNT_WIDTH  accepted redirects.
- `fetch_cnt_o`  out  CNT_WIDTH  completed fetch handshakes.

## Operation
- States: RUN, FLUSH, HALT. Reset → RUN, `pc_o`=RESET_PC, counters 0, flush counter 0.
- Outputs by state: RUN: `pc_valid_o`=1, `halted_o`=0. FLUSH: `pc_valid_o`=0, `flush_o`=1. HALT: `pc_valid_o`=0, `flush_o`=0, `halted_o`=1.
- RUN, priority high→low:
  - `ebreak_i`: → HALT; PC frozen; redirect ignored even if simultaneous.
  - `branch_jump_en_i`: `flush_o`=1 combinationally this cycle. At the next edge, `pc_o` ← `{branch_jump_addr_i[WIDTH-1:1],1'b0}` (bit 0 cleared for jalr; bit 1 kept). FSM → FLUSH with counter=FLUSH_CYCLES-1. `redirect_cnt_o`+1.
  - `hold_pipeline_en_i` alone: PC held; no handshake is counted even if `if_ready_i`=1.
  - Otherwise: if `if_ready_i`, `pc_o` ← `pc_o`+4 (mod 2^WIDTH) and `fetch_cnt_o`+1; else PC held.
  - A fetch handshake is `pc_valid_o & if_ready_i & !hold_pipeline_en_i & !branch_jump_en_i & !ebreak_i`.
- FLUSH:
  - Decrement the counter each cycle; → RUN when it is 0.
  - `branch_jump_en_i`, `ebreak_i`, `hold_pipeline_en_i` are ignored; they come from killed instructions.
  - PC holds the target.
- HALT: absorbing until `rst`; all inputs ignored, counters frozen.
- Counters wrap to 0 on overflow, no saturation.
- `rst` in any state, including mid-FLUSH, returns to reset values at that edge. The redirect target is discarded.

## Timing
- Redirect accepted in cycle T: `flush_o`=1 in T..T+FLUSH_CYCLES. `pc_valid_o`=0 in T+1..T+FLUSH_CYCLES. `pc_o`=target from T+1. First fetch of the target is offered at T+FLUSH_CYCLES+1.
- Sequential fetch: one PC per cycle while `if_ready_i` is held high; zero-cycle handshake.
- `pc_o` is stable while `pc_valid_o`=1 and `if_ready_i`=0.
- `flush_o` in RUN is combinational from `branch_jump_en_i`. All other outputs are registered or state-decoded.
- First cycle after `rst` deasserts: `pc_o`=RESET_PC, `pc_valid_o`=1.

## Test plan
- Reset, `if_ready_i`=1 for 4 cycles → `pc_o` = 8000_0000, _0004, _0008, _000C; `fetch_cnt_o`=4.
- `if_ready_i`=0 for 3 cycles at PC 8000_0008 → `pc_o` stays 8000_0008, `fetch_cnt_o` unchanged, `pc_valid_o`=1.
- Redirect at T with target 8000_0101, FLUSH_CYCLES=2 → `flush_o`=1 at T,T+1,T+2. `pc_valid_o`=0 at T+1,T+2. At T+3, `pc_o`=8000_0100 and `pc_valid_o`=1. `redirect_cnt_o`=1.
- Redirect at T+1 during FLUSH (target 8000_2000) → ignored. `pc_o` stays 8000_0100, `redirect_cnt_o` stays 1.
- `ebreak_i` and `branch_jump_en_i` together in RUN → HALT next cycle. `halted_o`=1, `pc_valid_o`=0, `flush_o`=0, PC unchanged. Stays in HALT for 10 cycles of random inputs; `rst` restores 8000_0000.
- Preload `fetch_cnt_o` near 2^CNT_WIDTH-1 (force or CNT_WIDTH=4 build), then 2 handshakes → wraps to 0, then 1. Also `rst` mid-FLUSH → next cycle RUN, `pc_o`=RESET_PC.
